video_capture: RTL

VIDEO_CAPTURE -- requirements
Module: video_capture

---
 rtl/video_capture.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/video_capture.sv
// video_capture: serial monochrome video to packed 8-pixel framebuffer writes.
// Define VIDEO_CAPTURE_GENLOCK_EN to build in frame lock tracking and the genlock pulse.
module video_capture #(
    parameter int H_START = 16,
    parameter int V_START = 2
) (
    input  logic        clk,
    input  logic        srst_n,
    input  logic        pix_stb,
    input  logic        vid_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic        wr_en,
    output logic [14:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        locked,
    output logic        genlock,
    output logic [9:0]  line_count
);

    localparam logic [9:0] H_FIRST = 10'(H_START);
    localparam logic [9:0] H_LAST  = 10'(H_START + 639);
    localparam logic [9:0] V_FIRST = 10'(V_START);
    localparam logic [9:0] V_LAST  = 10'(V_START + 239);
    localparam logic [9:0] CNT_MAX = 10'd1023;

    logic       vid_s1_q, vid_s1_d, vid_s2_q, vid_s2_d;
    logic       hs_s1_q, hs_s1_d, hs_s2_q, hs_s2_d, hs_prev_q, hs_prev_d;
    logic       vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d, vs_prev_q, vs_prev_d;
    logic [9:0] px_q, px_d;
    logic [9:0] ln_q, ln_d;
    logic [9:0] line_count_q, line_count_d;
    logic       frame_ok_q, frame_ok_d;
    logic [6:0] sh_q, sh_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       wr_en_q, wr_en_d;
    logic [14:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;

    logic       hs_fall, hs_edge, vs_fall, vs_edge;
    logic       pix_acc, in_win;
    logic [6:0] col;
    logic [7:0] row;

    always_comb begin
        vid_s1_d  = vid_in;
        vid_s2_d  = vid_s1_q;
        hs_s1_d   = hsync_in;
        hs_s2_d   = hs_s1_q;
        hs_prev_d = hs_s2_q;
        vs_s1_d   = vsync_in;
        vs_s2_d   = vs_s1_q;
        vs_prev_d = vs_s2_q;

        hs_fall = hs_prev_q & ~hs_s2_q;
        hs_edge = hs_prev_q ^ hs_s2_q;
        vs_fall = vs_prev_q & ~vs_s2_q;
        vs_edge = vs_prev_q ^ vs_s2_q;

        pix_acc = pix_stb & ~hs_s2_q;
        in_win  = (px_q >= H_FIRST) && (px_q <= H_LAST) &&
                  (ln_q >= V_FIRST) && (ln_q <= V_LAST);
        col     = 7'((px_q - H_FIRST) >> 3);
        row     = 8'(ln_q - V_FIRST);

        px_d = px_q;
        if (hs_fall) begin
            px_d = '0;
        end else if (pix_acc && (px_q != CNT_MAX)) begin
            px_d = px_q + 10'd1;
        end

        // vsync wins over a coincident hsync: the frame boundary resets the line count.
        ln_d         = ln_q;
        line_count_d = line_count_q;
        frame_ok_d   = frame_ok_q;
        if (vs_fall) begin
            ln_d         = '0;
            line_count_d = ln_q;
            frame_ok_d   = 1'b1;
        end else if (hs_fall && (ln_q != CNT_MAX)) begin
            ln_d = ln_q + 10'd1;
        end

        sh_d      = sh_q;
        bit_cnt_d = bit_cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (hs_edge || vs_edge) begin
            sh_d      = '0;
            bit_cnt_d = '0;
        end else if (pix_acc) begin
            if (frame_ok_q && in_win) begin
                if (bit_cnt_q == 3'd7) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = {sh_q, vid_s2_q};
                    wr_addr_d = {col, row};
                    sh_d      = '0;
                    bit_cnt_d = '0;
                end else begin
                    sh_d      = {sh_q[5:0], vid_s2_q};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end else begin
                // Leaving the window (or no frame yet) discards any partial byte.
                sh_d      = '0;
                bit_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            vid_s1_q     <= 1'b0;
            vid_s2_q     <= 1'b0;
            hs_s1_q      <= 1'b0;
            hs_s2_q      <= 1'b0;
            hs_prev_q    <= 1'b0;
            vs_s1_q      <= 1'b0;
            vs_s2_q      <= 1'b0;
            vs_prev_q    <= 1'b0;
            px_q         <= '0;
            ln_q         <= '0;
            line_count_q <= '0;
            frame_ok_q   <= 1'b0;
            sh_q         <= '0;
            bit_cnt_q    <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            vid_s1_q     <= vid_s1_d;
            vid_s2_q     <= vid_s2_d;
            hs_s1_q      <= hs_s1_d;
            hs_s2_q      <= hs_s2_d;
            hs_prev_q    <= hs_prev_d;
            vs_s1_q      <= vs_s1_d;
            vs_s2_q      <= vs_s2_d;
            vs_prev_q    <= vs_prev_d;
            px_q         <= px_d;
            ln_q         <= ln_d;
            line_count_q <= line_count_d;
            frame_ok_q   <= frame_ok_d;
            sh_q         <= sh_d;
            bit_cnt_q    <= bit_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign line_count = line_count_q;

`ifdef VIDEO_CAPTURE_GENLOCK_EN
    logic locked_q, locked_d;
    logic genlock_q, genlock_d;

    // Lock is judged at each frame boundary against the previous frame's line count.
    always_comb begin
        locked_d = locked_q;
        if (vs_fall) begin
            locked_d = (ln_q == line_count_q) && (ln_q != '0) && (ln_q != CNT_MAX);
        end else if (ln_q == CNT_MAX) begin
            locked_d = 1'b0;
        end
        genlock_d = locked_q & vs_s2_q & ~vs_prev_q;
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            locked_q  <= 1'b0;
            genlock_q <= 1'b0;
        end else begin
            locked_q  <= locked_d;
            genlock_q <= genlock_d;
        end
    end

    assign locked  = locked_q;
    assign genlock = genlock_q;
`else
    assign locked  = 1'b0;
    assign genlock = 1'b0;
`endif

endmodule
